// File: rtl/codec_cfg_seq_if.sv
// Bus bundle between the codec configuration sequencer and its environment.
// Covers the host write request path and the I2C controller start/packet path.
interface codec_cfg_seq_if;
  logic        cfg_req;
  logic [6:0]  cfg_addr;
  logic [8:0]  cfg_data;
  logic        cfg_ack;
  logic        i2c_idle;
  logic        wr_i2c;
  logic [23:0] i2c_packet;

  // master: host plus I2C controller side; slave: the sequencer itself
  modport master (
    output cfg_req, cfg_addr, cfg_data, i2c_idle,
    input  cfg_ack, wr_i2c, i2c_packet
  );
  modport slave (
    input  cfg_req, cfg_addr, cfg_data, i2c_idle,
    output cfg_ack, wr_i2c, i2c_packet
  );
endinterface

// File: rtl/codec_cfg_seq.sv
// WM8731 configuration sequencer: power-up delay, fixed register table over I2C,
// then arbitration of single host register writes onto the same controller.
module codec_cfg_seq #(
  parameter logic [6:0] DEV_ADDR = 7'h1A,
  parameter int         PWR_DLY  = 1000,
  parameter int         BUSY_TO  = 64
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           restart,
  codec_cfg_seq_if.slave bus,
  output logic           init_done,
  output logic           busy,
  output logic           timeout
);
  localparam int CNT_MAX = (PWR_DLY > BUSY_TO) ? PWR_DLY : BUSY_TO;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(PWR_DLY - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(BUSY_TO - 1);
  localparam logic [3:0]       LAST_IDX = 4'd11;

  localparam logic [2:0] ST_PWR    = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_ISSUE  = 3'd2;
  localparam logic [2:0] ST_WBUSY  = 3'd3;
  localparam logic [2:0] ST_WIDLE  = 3'd4;
  localparam logic [2:0] ST_READY  = 3'd5;
  localparam logic [2:0] ST_HISSUE = 3'd6;

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       idx;
  logic [15:0]      entry;

  // {reg[6:0], data[8:0]}; the trailing R6 write powers the outputs up last
  function automatic logic [15:0] table_entry(input logic [3:0] i);
    case (i)
      4'd0:    table_entry = {7'd15, 9'h000};
      4'd1:    table_entry = {7'd6,  9'h010};
      4'd2:    table_entry = {7'd0,  9'h017};
      4'd3:    table_entry = {7'd1,  9'h017};
      4'd4:    table_entry = {7'd2,  9'h079};
      4'd5:    table_entry = {7'd3,  9'h079};
      4'd6:    table_entry = {7'd4,  9'h012};
      4'd7:    table_entry = {7'd5,  9'h000};
      4'd8:    table_entry = {7'd7,  9'h00A};
      4'd9:    table_entry = {7'd8,  9'h000};
      4'd10:   table_entry = {7'd9,  9'h001};
      default: table_entry = {7'd6,  9'h000};
    endcase
  endfunction

  assign entry = table_entry(idx);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= ST_PWR;
      cnt            <= '0;
      idx            <= '0;
      bus.wr_i2c     <= 1'b0;
      bus.cfg_ack    <= 1'b0;
      bus.i2c_packet <= '0;
      init_done      <= 1'b0;
      busy           <= 1'b1;
      timeout        <= 1'b0;
    end else begin
      bus.wr_i2c  <= 1'b0;
      bus.cfg_ack <= 1'b0;
      case (state)
        ST_PWR: begin
          if (cnt == PWR_LAST) begin
            cnt   <= '0;
            state <= ST_LOAD;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_LOAD: begin
          bus.i2c_packet <= {DEV_ADDR, 1'b0, entry};
          state          <= ST_ISSUE;
        end
        ST_ISSUE, ST_HISSUE: begin
          if (bus.i2c_idle) begin
            bus.wr_i2c <= 1'b1;
            cnt        <= '0;
            state      <= ST_WBUSY;
          end
        end
        ST_WBUSY: begin
          // a controller that never leaves idle is flagged but does not stall the table
          if (!bus.i2c_idle) begin
            state <= ST_WIDLE;
          end else if (cnt == TO_LAST) begin
            timeout <= 1'b1;
            state   <= ST_WIDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_WIDLE: begin
          if (bus.i2c_idle) begin
            if (init_done) begin
              busy  <= 1'b0;
              state <= ST_READY;
            end else if (idx == LAST_IDX) begin
              init_done <= 1'b1;
              busy      <= 1'b0;
              state     <= ST_READY;
            end else begin
              idx   <= idx + 4'd1;
              state <= ST_LOAD;
            end
          end
        end
        ST_READY: begin
          // restart has priority; a simultaneous host request simply stays pending
          if (restart) begin
            init_done <= 1'b0;
            timeout   <= 1'b0;
            idx       <= '0;
            busy      <= 1'b1;
            state     <= ST_LOAD;
          end else if (bus.cfg_req) begin
            bus.i2c_packet <= {DEV_ADDR, 1'b0, bus.cfg_addr, bus.cfg_data};
            bus.cfg_ack    <= 1'b1;
            busy           <= 1'b1;
            state          <= ST_HISSUE;
          end
        end
        default: state <= ST_PWR;
      endcase
    end
  end
endmodule

// File: tb/tb_codec_cfg_seq.sv
// Scoreboard bench for codec_cfg_seq: stimulus queues expected packets, a monitor
// pops and compares on every wr_i2c pulse, and a behavioural I2C controller drives idle.
module tb_codec_cfg_seq;
  localparam int PWR_DLY = 1000;
  localparam int BUSY_TO = 64;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic restart = 1'b0;
  logic init_done, busy, timeout;

  codec_cfg_seq_if bus();

  codec_cfg_seq #(.DEV_ADDR(7'h1A), .PWR_DLY(PWR_DLY), .BUSY_TO(BUSY_TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .restart   (restart),
    .bus       (bus),
    .init_done (init_done),
    .busy      (busy),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [23:0] exp_q[$];
  int wr_count = 0;
  int pkt_no = 0;
  int busy_left = 0;
  int stuck_pkt = -1;
  bit hold_low = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // hand-computed packets {8'h34, reg[6:0], data[8:0]}
  function automatic logic [23:0] table_pkt(input int i);
    case (i)
      0:  table_pkt = 24'h341E00;
      1:  table_pkt = 24'h340C10;
      2:  table_pkt = 24'h340017;
      3:  table_pkt = 24'h340217;
      4:  table_pkt = 24'h340479;
      5:  table_pkt = 24'h340679;
      6:  table_pkt = 24'h340812;
      7:  table_pkt = 24'h340A00;
      8:  table_pkt = 24'h340E0A;
      9:  table_pkt = 24'h341000;
      10: table_pkt = 24'h341201;
      default: table_pkt = 24'h340C00;
    endcase
  endfunction

  task automatic push_table();
    for (int i = 0; i < 12; i++) exp_q.push_back(table_pkt(i));
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!(init_done && !busy) && n < 500) begin
      tick();
      n++;
    end
    check(name, {30'd0, init_done, busy}, 32'h2);
  endtask

  task automatic wait_pulses(input string name, input int target);
    int n = 0;
    while (wr_count < target && n < 3000) begin
      tick();
      n++;
    end
    check(name, wr_count, target);
  endtask

  task automatic wait_init(input string name);
    int n = 0;
    while (!init_done && n < 3000) begin
      tick();
      n++;
    end
    check(name, init_done, 1);
  endtask

  // I2C controller model: reacts on the falling edge so the DUT sees stable idle
  initial begin
    bus.i2c_idle = 1'b1;
    forever begin
      @(negedge clk);
      #1;
      if (bus.wr_i2c === 1'b1) begin
        if (pkt_no != stuck_pkt) busy_left = 10;
        pkt_no++;
      end else if (busy_left > 0) begin
        busy_left--;
      end
      bus.i2c_idle = !(hold_low || busy_left > 0);
    end
  end

  // scoreboard monitor
  always @(posedge clk) begin
    #1;
    if (bus.wr_i2c === 1'b1) begin
      wr_count++;
      check("wr_while_not_idle", bus.i2c_idle, 1);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_packet: got %0h expected none", bus.i2c_packet);
      end else begin
        logic [23:0] e;
        e = exp_q.pop_front();
        checks--;
        check("packet", bus.i2c_packet, e);
        $display("wr_i2c #%0d packet %06h expected %06h", wr_count, bus.i2c_packet, e);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int base;
    bit flag;
    bus.cfg_req  = 1'b0;
    bus.cfg_addr = '0;
    bus.cfg_data = '0;

    // reset state
    repeat (3) tick();
    check("rst_wr", bus.wr_i2c, 0);
    check("rst_ack", bus.cfg_ack, 0);
    check("rst_init_done", init_done, 0);
    check("rst_timeout", timeout, 0);
    check("rst_busy", busy, 1);
    check("rst_packet", bus.i2c_packet, 0);

    // power-up table with a host request pending from the start
    @(negedge clk);
    push_table();
    exp_q.push_back(24'h34047F);
    base = wr_count;
    reset = 1'b1;
    bus.cfg_req = 1'b1; bus.cfg_addr = 7'h02; bus.cfg_data = 9'h07F;
    n = 0;
    while (bus.wr_i2c !== 1'b1 && n < PWR_DLY + 20) begin
      tick();
      n++;
    end
    check("first_wr_latency", n, PWR_DLY + 2);
    check("init_busy", busy, 1);
    flag = 1'b0;
    n = 0;
    while (!init_done && n < 3000) begin
      if (bus.cfg_ack) flag = 1'b1;
      tick();
      n++;
    end
    if (bus.cfg_ack) flag = 1'b1;
    check("init_done_set", init_done, 1);
    check("no_ack_before_init", flag, 0);
    check("init_pulses", wr_count - base, 12);
    check("ready_busy", busy, 0);
    tick();
    check("ack_after_init", bus.cfg_ack, 1);
    @(negedge clk); bus.cfg_req = 1'b0;
    tick();
    check("host_wr_latency", bus.wr_i2c, 1);
    check("host_packet", bus.i2c_packet, 24'h34047F);
    wait_ready("ready_after_host");

    // controller held busy: request is acked but not issued until idle returns
    @(negedge clk); hold_low = 1'b1;
    tick(); tick();
    check("hold_idle_low", bus.i2c_idle, 0);
    @(negedge clk);
    exp_q.push_back(24'h340BC3);
    bus.cfg_req = 1'b1; bus.cfg_addr = 7'h05; bus.cfg_data = 9'h1C3;
    tick();
    check("hold_ack", bus.cfg_ack, 1);
    @(negedge clk); bus.cfg_req = 1'b0;
    flag = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (bus.wr_i2c) flag = 1'b1;
    end
    check("no_wr_in_hold", flag, 0);
    @(negedge clk); hold_low = 1'b0;
    tick();
    check("idle_back", bus.i2c_idle, 1);
    check("wr_1cyc_after_idle", bus.wr_i2c, 1);
    wait_ready("ready_after_hold");

    // restart and host request together: table first, host write afterwards
    @(negedge clk);
    push_table();
    exp_q.push_back(24'h340855);
    base = wr_count;
    restart = 1'b1;
    bus.cfg_req = 1'b1; bus.cfg_addr = 7'h04; bus.cfg_data = 9'h055;
    tick();
    check("restart_init_done", init_done, 0);
    check("restart_no_ack", bus.cfg_ack, 0);
    @(negedge clk); restart = 1'b0;
    n = 0;
    while (!bus.cfg_ack && n < 3000) begin
      tick();
      n++;
    end
    check("restart_ack", bus.cfg_ack, 1);
    check("restart_pulses_before_ack", wr_count - base, 12);
    @(negedge clk); bus.cfg_req = 1'b0;
    tick();
    check("restart_host_wr", bus.wr_i2c, 1);
    wait_ready("ready_after_restart");

    // reset, then packet 3 never leaves idle: timeout, table still completes
    @(negedge clk); reset = 1'b0;
    tick();
    @(negedge clk);
    stuck_pkt = pkt_no + 3;
    base = wr_count;
    push_table();
    reset = 1'b1;
    wait_pulses("reach_pkt3", base + 4);
    n = 0;
    while (!timeout && n < BUSY_TO + 20) begin
      tick();
      n++;
    end
    check("timeout_delay", n, BUSY_TO);
    check("timeout_before_done", init_done, 0);
    @(negedge clk); restart = 1'b1;
    @(negedge clk); restart = 1'b0;
    wait_init("init_after_timeout");
    check("timeout_pulses", wr_count - base, 12);
    check("timeout_sticky", timeout, 1);
    wait_ready("ready_after_timeout");
    stuck_pkt = -1;

    // restart clears timeout; reset during entry 5 aborts the table
    @(negedge clk);
    push_table();
    base = wr_count;
    restart = 1'b1;
    tick();
    check("restart_clr_timeout", timeout, 0);
    @(negedge clk); restart = 1'b0;
    wait_pulses("reach_idx5", base + 6);
    #1 reset = 1'b0;
    #1;
    check("midrst_wr", bus.wr_i2c, 0);
    check("midrst_ack", bus.cfg_ack, 0);
    check("midrst_init_done", init_done, 0);
    check("midrst_busy", busy, 1);
    check("midrst_packet", bus.i2c_packet, 0);
    exp_q.delete();
    repeat (2) tick();
    @(negedge clk);
    base = wr_count;
    push_table();
    reset = 1'b1;
    wait_init("init_after_midrst");
    check("midrst_pulses", wr_count - base, 12);
    wait_ready("ready_final");

    check("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
